image_blend_stream: RTL
=======================

Name: image_blend_stream

Overview:
- Streaming two-image alpha-blend engine: the hardware end of the pixel stimulus the image benches drive.
- Accepts paired 8-bit pixels from image A and image B over a valid/ready handshake.
- Scales each pixel by a per-frame weight through a multiplier3 instance, or an exact multiplier when EXACT=1.
- Outputs the blended pixel stream with an end-of-frame marker; sits between the frame fetch logic and the output frame writer.

Parameters:
- PIXELS, 90000: pixels per frame (300x300); range 1 to 2^17-1.
- EXACT, 0: 0 = both products from multiplier3 instances; 1 = exact 8x8 products (golden/verification build).

Ports:
- clk  input  1  clock, all state on rising edge
- rst_n  input  1  asynchronous active-low reset
- w_a  input  8  weight for image A; sampled at frame start
- w_b  input  8  weight for image B; sampled at frame start
- in_valid  input  1  pixel pair valid
- in_ready  output  1  engine can accept the pair this cycle
- pix_a  input  8  image A pixel
- pix_b  input  8  image B pixel
- out_valid  output  1  blended pixel valid
- out_ready  input  1  downstream accepts the output this cycle
- out_pix  output  8  blended pixel
- out_last  output  1  out_pix is the final pixel of the frame
- frame_cnt  output  8  completed frames, wraps at 256

Behaviour:
- Reset (async assert, release sync to clk):
  - out_valid=0, out_pix=0, out_last=0, frame_cnt=0.
  - Pixel counter 0, all stage valids 0, latched weights 0.
- Pipeline:
  - Three register stages: S1 input, S2 products, S3 output.
  - Global advance en = !out_valid || out_ready.
  - in_ready = en, combinationally.
  - A pair is accepted when in_valid && in_ready.
  - Latency: an accepted pair appears on out_valid exactly 3 cycles later, given no stall.
  - Full throughput: 1 pixel/clk while out_ready=1.
- Stall: when en=0, every stage holds, including valids, data and out_last. Output data must stay stable while out_valid && !out_ready.
- S1:
  - Captures pix_a, pix_b, a valid bit and a last flag.
  - last = (accept-side counter == PIXELS-1).
  - When in_valid=0 and en=1, the valid bit is cleared.
- Weights:
  - On an accepted pair with accept counter == 0, w_a/w_b are latched and used for that pixel and the whole frame.
  - Weight changes mid-frame have no effect.
- S2:
  - p_a = mult(S1.pix_a, wa_latched)[15:8]; p_b = mult(S1.pix_b, wb_latched)[15:8].
  - Weights follow their pixel through S1 so that a frame boundary in flight stays correct.
- S3: out_pix = p_a + p_b, width rule per BLEND_SAT_EN; out_last = S2 last flag.
- Accept counter (17 bits):
  - Increments per accepted pair.
  - Wraps PIXELS-1 -> 0; no idle gap between frames.
- frame_cnt: increments on each output handshake (out_valid && out_ready) with out_last=1; wraps 255 -> 0.
- Boundary conditions:
  - PIXELS=1: every pixel is last, and weights are latched on every accept.
  - Simultaneous accept at the tail and output at the head is legal every cycle.
  - Reset mid-frame discards all in-flight pixels; the next accepted pair is pixel 0.
  - Bubbles (in_valid=0) propagate as out_valid=0 holes.

Optional Feature:
- Macro: BLEND_SAT_EN.
  - Defined: out_pix = min(p_a + p_b, 8'hFF), computed as a 9-bit sum then clamped.
  - Undefined: out_pix = (p_a + p_b) mod 256, i.e. 8-bit wrap. This matches the existing blend flow's output images.

Test Plan:
- Basic blend, EXACT=1, w_a=w_b=8'h80, pix_a=8'hC8, pix_b=8'h64, out_ready=1 -> out_pix=8'h96 exactly 3 cycles after accept.
- Overflow, EXACT=1, w_a=w_b=8'hFF, pix_a=pix_b=8'hFF:
  - Without BLEND_SAT_EN -> out_pix=8'hFC.
  - With BLEND_SAT_EN -> out_pix=8'hFF.
- Backpressure: stream 8 pairs, hold out_ready=0 for cycles 4-9.
  - in_ready=0 during the stall; out_pix and out_last stable.
  - All 8 outputs arrive in order, none lost or duplicated.
- Frame boundary, PIXELS=4, EXACT=1:
  - w_a=w_b=8'h80 for frame 0; change to w_a=8'h40, w_b=8'h00 at pixel 2 and keep them for frame 1.
  - Frame 0 uses 0x80/0x80 for all 4 pixels.
  - out_last on outputs 3 and 7; frame_cnt = 1 then 2.
  - Frame 1 with pix_a=8'hC8 -> out_pix=8'h32.
- Reset mid-frame: assert rst_n=0 after 2 of 4 pixels of a frame (PIXELS=4).
  - Outputs drop to 0 immediately, asynchronously.
  - After release the next 4 accepts form a full frame, with out_last on the 4th.
- EXACT=0 regression: random 10000 pairs, w_a=w_b=8'h80.
  - out_pix must equal a reference model built from two multiplier3 instances: sum of y[15:8], mod-256 wrap when BLEND_SAT_EN is undefined, clamped to 8'hFF when it is defined.

Source files
------------

// File: rtl/image_blend_stream.sv
// image_blend_stream: three-stage streaming two-image alpha blend over valid/ready.
// Optional macro BLEND_SAT_EN: clamp the blended sum at 8'hFF instead of wrapping mod 256.

module multiplier3 #(
    parameter int DROP_COLS = 3
) (
    input  logic [7:0]  a_i,
    input  logic [7:0]  b_i,
    output logic [15:0] y_o
);
    // Truncated array multiplier: partial-product bits in columns below DROP_COLS are never summed.
    logic [7:0] row;

    always_comb begin
        // NOTE: every always_comb output gets a default first, so no path can infer a latch.
        y_o = '0;
        row = '0;
        for (int j = 0; j < 8; j++) begin
            for (int i = 0; i < 8; i++) begin
                row[i] = (i + j >= DROP_COLS) ? (a_i[i] & b_i[j]) : 1'b0;
            end
            y_o = y_o + ({8'h00, row} << j);
        end
    end
endmodule

module image_blend_stream #(
    parameter int PIXELS = 90000,
    parameter int EXACT  = 0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] w_a,
    input  logic [7:0] w_b,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] pix_a,
    input  logic [7:0] pix_b,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] out_pix,
    output logic       out_last,
    output logic [7:0] frame_cnt
);
    localparam logic [16:0] LAST_IDX = 17'(PIXELS - 1);

    typedef struct packed {
        logic       valid;
        logic       last;
        logic [7:0] pix_a;
        logic [7:0] pix_b;
        logic [7:0] w_a;
        logic [7:0] w_b;
    } s1_t;

    typedef struct packed {
        logic       valid;
        logic       last;
        logic [7:0] p_a;
        logic [7:0] p_b;
    } s2_t;

    typedef struct packed {
        logic       valid;
        logic       last;
        logic [7:0] pix;
    } s3_t;

    s1_t         s1_q, s1_d;
    s2_t         s2_q, s2_d;
    s3_t         s3_q, s3_d;
    logic [16:0] acc_cnt_q, acc_cnt_d;
    logic [7:0]  wa_lat_q, wa_lat_d;
    logic [7:0]  wb_lat_q, wb_lat_d;
    logic [7:0]  frame_cnt_q, frame_cnt_d;

    logic        en;
    logic        accept;
    logic        first_px;
    logic        last_px;
    logic [7:0]  w_a_sel;
    logic [7:0]  w_b_sel;
    logic [15:0] prod_a;
    logic [15:0] prod_b;
    logic [7:0]  blend;
    logic        unused_prod_lo;

    assign en       = !s3_q.valid || out_ready;
    assign accept   = in_valid && en;
    assign first_px = (acc_cnt_q == '0);
    assign last_px  = (acc_cnt_q == LAST_IDX);
    // Pixel 0 of a frame uses the live weights; they travel with the pixel so a frame edge in flight is exact.
    assign w_a_sel  = first_px ? w_a : wa_lat_q;
    assign w_b_sel  = first_px ? w_b : wb_lat_q;

    if (EXACT != 0) begin : g_exact
        assign prod_a = {8'h00, s1_q.pix_a} * {8'h00, s1_q.w_a};
        assign prod_b = {8'h00, s1_q.pix_b} * {8'h00, s1_q.w_b};
    end else begin : g_approx
        multiplier3 u_mul_a (.a_i(s1_q.pix_a), .b_i(s1_q.w_a), .y_o(prod_a));
        multiplier3 u_mul_b (.a_i(s1_q.pix_b), .b_i(s1_q.w_b), .y_o(prod_b));
    end

    assign unused_prod_lo = ^{prod_a[7:0], prod_b[7:0]};

`ifdef BLEND_SAT_EN
    logic [8:0] sum;
    assign sum   = {1'b0, s2_q.p_a} + {1'b0, s2_q.p_b};
    assign blend = sum[8] ? 8'hFF : sum[7:0];
`else
    assign blend = s2_q.p_a + s2_q.p_b;
`endif

    always_comb begin
        s1_d        = s1_q;
        s2_d        = s2_q;
        s3_d        = s3_q;
        acc_cnt_d   = acc_cnt_q;
        wa_lat_d    = wa_lat_q;
        wb_lat_d    = wb_lat_q;
        frame_cnt_d = frame_cnt_q;

        if (accept) begin
            acc_cnt_d = last_px ? '0 : acc_cnt_q + 17'd1;
            if (first_px) begin
                wa_lat_d = w_a;
                wb_lat_d = w_b;
            end
        end

        // One global enable: a stall freezes every stage, valids and data alike.
        if (en) begin
            s1_d = '{valid: in_valid, last: last_px, pix_a: pix_a, pix_b: pix_b,
                     w_a: w_a_sel, w_b: w_b_sel};
            s2_d = '{valid: s1_q.valid, last: s1_q.last,
                     p_a: prod_a[15:8], p_b: prod_b[15:8]};
            s3_d = '{valid: s2_q.valid, last: s2_q.last, pix: blend};
        end

        if (s3_q.valid && out_ready && s3_q.last) begin
            frame_cnt_d = frame_cnt_q + 8'd1;
        end
    end

    // NOTE: state registers use non-blocking assignments and reset asynchronously; data is
    // reset too because out_pix must read 0 while in reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q        <= '0;
            s2_q        <= '0;
            s3_q        <= '0;
            acc_cnt_q   <= '0;
            wa_lat_q    <= '0;
            wb_lat_q    <= '0;
            frame_cnt_q <= '0;
        end else begin
            s1_q        <= s1_d;
            s2_q        <= s2_d;
            s3_q        <= s3_d;
            acc_cnt_q   <= acc_cnt_d;
            wa_lat_q    <= wa_lat_d;
            wb_lat_q    <= wb_lat_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

    assign in_ready  = en;
    assign out_valid = s3_q.valid;
    assign out_pix   = s3_q.pix;
    assign out_last  = s3_q.last;
    assign frame_cnt = frame_cnt_q;
endmodule
